// File: rtl/fp_expand.sv
// fp_expand: converts a small sign/exponent/significand word into a 13-bit
// two's-complement linear value.
// A four-state FSM does the conversion one bit per clock, so a word takes
// E+2 edges from accept to result.
// The result is held in D until the consumer takes it.
module fp_expand (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        S,
  input  logic [2:0]  E,
  input  logic [4:0]  F,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [12:0] D
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] SIGN  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]  state;
  logic        sgn;
  logic [12:0] mag;
  logic [2:0]  cnt;

  // Conditional two's-complement negation of the unsigned magnitude.
  // The magnitude never exceeds 3968, so it always fits as a positive
  // 13-bit signed value. A zero magnitude negates to zero.
  function automatic logic signed [12:0] apply_sign(input logic neg,
                                                    input logic [12:0] m);
    logic signed [12:0] v;
    v = $signed(m);
    return neg ? -v : v;
  endfunction

  // The block is ready to accept a word only while idle.
  assign in_ready = (state == IDLE);

  // Control FSM: IDLE -> SHIFT (E shift steps) -> SIGN -> DONE -> IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (in_valid)      state <= SHIFT;
        SHIFT:   if (cnt == 3'd0)   state <= SIGN;
        SIGN:                       state <= DONE;
        DONE:    if (out_ready)     state <= IDLE;
        default:                    state <= IDLE;
      endcase
    end
  end

  // Working registers.
  // The inputs are captured once at accept, so later changes on S/E/F
  // cannot disturb a conversion in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sgn <= 1'b0;
      mag <= 13'd0;
      cnt <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sgn <= S;
            mag <= {8'b0, F};
            cnt <= E;
          end
        end
        SHIFT: begin
          if (cnt != 3'd0) begin
            mag <= {mag[11:0], 1'b0};
            cnt <= cnt - 3'd1;
          end
        end
        default: begin
          sgn <= sgn;
          mag <= mag;
          cnt <= cnt;
        end
      endcase
    end
  end

  // Output register: D keeps its last value after the handshake; out_valid
  // is high only in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      D         <= 13'h0000;
      out_valid <= 1'b0;
    end else begin
      case (state)
        SIGN: begin
          D         <= apply_sign(sgn, mag);
          out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
